// File: rtl/shift_seq_ctrl.sv
// Serial frame sequencer: serializes a parallel word onto serial_out, strobes an
// external shift register, and reassembles the returned serial_in bits into rx_data.
module shift_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             shift_en,
  output logic             frame,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             aborted
);

  // One counter serves both the bit count (up to 31) and the gap count (up to 15).
  localparam int CW = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    GAPW
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] rx_word;
  logic             aborted_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)         state_nxt = IDLE;
        else if (cnt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = (GAP > 0) ? GAPW : IDLE;
      GAPW:    if (abort || cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register contents including the bit sampled at the edge ending this cycle.
  assign rx_word = LSB_FIRST ? {serial_in, rx_sr[WIDTH-1:1]}
                             : {rx_sr[WIDTH-2:0], serial_in};

  // NOTE: the datapath registers are reset too, because rx_data is visible and
  // must read zero after reset; these are flops, not a memory array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= (state == SHIFT) && abort;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_sr <= tx_data;
            cnt   <= CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          // An abort freezes the shift path; the partial word is discarded.
          if (!abort) begin
            tx_sr <= LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);
            rx_sr <= rx_word;
            cnt   <= cnt - 1'b1;
            if (cnt == '0) rx_data <= rx_word;
          end
        end
        DONE: cnt <= (GAP > 0) ? CW'(GAP - 1) : '0;
        GAPW: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign tx_ready   = (state == IDLE);
  assign frame      = (state == SHIFT);
  assign shift_en   = (state == SHIFT);
  assign serial_out = (state == SHIFT) && (LSB_FIRST ? tx_sr[0] : tx_sr[WIDTH-1]);
  assign rx_valid   = (state == DONE);
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (MSB-first GAP=1, LSB-first GAP=0) driven
// by directed and random frames, checked against a per-frame timeline model.
module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] tx_data [2];
  logic [W-1:0] rx_data [2];
  logic [1:0]   tx_valid, abort, loopb, sin_rnd, serial_in;
  logic [1:0]   tx_ready, serial_out, shift_en, frame, rx_valid, aborted;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last_acc [2];
  bit           prev_done [2];
  logic [W-1:0] prev_rx [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign serial_in = (loopb & serial_out) | (~loopb & sin_rnd);

  shift_seq_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0), .GAP(1)) u0 (
    .clk(clk), .reset(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .abort(abort[0]), .serial_in(serial_in[0]),
    .serial_out(serial_out[0]), .shift_en(shift_en[0]), .frame(frame[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .aborted(aborted[0])
  );

  shift_seq_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP(0)) u1 (
    .clk(clk), .reset(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .abort(abort[1]), .serial_in(serial_in[1]),
    .serial_out(serial_out[1]), .shift_en(shift_en[1]), .frame(frame[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .aborted(aborted[1])
  );

  function automatic int gap_of(input int s);
    return (s == 0) ? 1 : 0;
  endfunction

  function automatic bit lsb_of(input int s);
    return (s == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input int s, input string tag, input bit e_frame, input bit e_so,
                         input bit e_rdy, input bit e_rv, input bit e_ab,
                         input logic [W-1:0] e_rx);
    check($sformatf("u%0d %s frame", s, tag),      32'(frame[s]),      32'(e_frame));
    check($sformatf("u%0d %s shift_en", s, tag),   32'(shift_en[s]),   32'(e_frame));
    check($sformatf("u%0d %s serial_out", s, tag), 32'(serial_out[s]), 32'(e_so));
    check($sformatf("u%0d %s tx_ready", s, tag),   32'(tx_ready[s]),   32'(e_rdy));
    check($sformatf("u%0d %s rx_valid", s, tag),   32'(rx_valid[s]),   32'(e_rv));
    check($sformatf("u%0d %s aborted", s, tag),    32'(aborted[s]),    32'(e_ab));
    check($sformatf("u%0d %s rx_data", s, tag),    32'(rx_data[s]),    32'(e_rx));
  endtask

  // Called and returning at a falling edge with the addressed instance idle.
  // abort_at: shift cycle index 0..W-1 to abort, W to raise abort through DONE/GAPW, -1 none.
  task automatic send_frame(input int s, input logic [W-1:0] word, input bit lb,
                            input logic [W-1:0] sin_word, input int abort_at,
                            input bit hold, input bit abort_idle, input int reset_at);
    logic [W-1:0] exp_rx;
    int           g;
    bit           lsb;
    g      = gap_of(s);
    lsb    = lsb_of(s);
    exp_rx = lb ? word : sin_word;
    tx_valid[1-s] = 1'b0;
    prev_done[1-s] = 1'b0;
    check($sformatf("u%0d ready-in", s), 32'(tx_ready[s]), 32'd1);
    tx_data[s]  = word;
    tx_valid[s] = 1'b1;
    loopb[s]    = lb;
    abort[s]    = abort_idle;
    @(posedge clk);
    @(negedge clk);
    abort[s] = 1'b0;
    if (!hold) tx_valid[s] = 1'b0;
    if (prev_done[s]) check($sformatf("u%0d spacing", s), 32'(cyc - last_acc[s]), 32'(W + 2 + g));
    last_acc[s]  = cyc;
    prev_done[s] = 1'b0;
    for (int i = 0; i < W; i++) begin
      logic b;
      b = lsb ? word[i] : word[W-1-i];
      chk_out(s, $sformatf("shift%0d", i), 1'b1, b, 1'b0, 1'b0, 1'b0, prev_rx[s]);
      sin_rnd[s] = lsb ? sin_word[i] : sin_word[W-1-i];
      if (hold) tx_data[s] = W'($urandom);
      if (abort_at == i) abort[s] = 1'b1;
      if (reset_at == i) begin
        rst = 1'b1;
        #1;
        chk_out(s, "async-reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tx_valid[s] = 1'b0;
        @(negedge clk);
        chk_out(s, "held-reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        rst = 1'b0;
        prev_rx[0] = '0;
        prev_rx[1] = '0;
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        return;
      end
      @(negedge clk);
      if (abort_at == i) begin
        abort[s]    = 1'b0;
        tx_valid[s] = 1'b0;
        chk_out(s, "abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, prev_rx[s]);
        @(negedge clk);
        chk_out(s, "post-abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, prev_rx[s]);
        return;
      end
    end
    chk_out(s, "done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_rx);
    if (abort_at == W) abort[s] = 1'b1;
    for (int k = 0; k < g; k++) begin
      @(negedge clk);
      chk_out(s, "gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_rx);
    end
    @(negedge clk);
    abort[s] = 1'b0;
    chk_out(s, "idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_rx);
    prev_rx[s]   = exp_rx;
    prev_done[s] = 1'b1;
  endtask

  // Idle cycles with random abort on both instances: nothing may move.
  task automatic idle(input int n);
    tx_valid = '0;
    prev_done[0] = 1'b0;
    prev_done[1] = 1'b0;
    for (int k = 0; k < n; k++) begin
      abort = 2'($urandom);
      @(negedge clk);
      chk_out(0, "idle-wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, prev_rx[0]);
      chk_out(1, "idle-wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, prev_rx[1]);
    end
    abort = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    tx_valid   = '0;
    abort      = '0;
    loopb      = '0;
    sin_rnd    = '0;
    tx_data[0] = '0;
    tx_data[1] = '0;
    prev_rx[0] = '0;
    prev_rx[1] = '0;
    prev_done[0] = 1'b0;
    prev_done[1] = 1'b0;
    last_acc[0] = 0;
    last_acc[1] = 0;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_out(0, "reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk_out(1, "reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    tx_valid[0] = 1'b0;
    rst = 1'b0;

    // Loopback MSB-first, accepted on the first edge after reset release.
    send_frame(0, 8'hB2, 1'b1, '0, -1, 1'b0, 1'b0, -1);
    // Loopback LSB-first single set bit.
    send_frame(1, 8'h01, 1'b1, '0, -1, 1'b0, 1'b0, -1);
    idle(1);
    // GAP=0 with tx_valid held: accepts W+2 apart.
    send_frame(1, 8'hA5, 1'b1, '0, -1, 1'b1, 1'b0, -1);
    send_frame(1, 8'h3C, 1'b1, '0, -1, 1'b1, 1'b0, -1);
    idle(2);
    // Abort in 4th shift cycle keeps previous rx_data.
    send_frame(0, 8'h5A, 1'b1, '0, 3, 1'b0, 1'b0, -1);
    // Abort in IDLE alongside tx_valid: accept still happens.
    send_frame(0, 8'hC3, 1'b1, '0, -1, 1'b0, 1'b1, -1);
    // Abort through DONE and GAPW: frame completes, no aborted pulse.
    send_frame(0, 8'h96, 1'b1, '0, W, 1'b0, 1'b0, -1);
    // Reset in the 5th shift cycle, then a full frame right after release.
    send_frame(0, 8'h77, 1'b1, '0, -1, 1'b0, 1'b0, 4);
    send_frame(0, 8'hFF, 1'b1, '0, -1, 1'b0, 1'b0, -1);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      int s;
      int ab;
      s  = int'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
      send_frame(s, W'($urandom), 1'($urandom), W'($urandom), ab,
                 1'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
